// File: rtl/frame_manager_pkg.sv
// Frame geometry and colour constants shared by the frame manager blocks.
// Pure constants; no logic.
package frame_manager_pkg;
    localparam int DRAW_WIDTH        = 320;
    localparam int DRAW_HEIGHT       = 240;
    localparam int DRAW_WIDTH_ADDRW  = 9;
    localparam int DRAW_HEIGHT_ADDRW = 8;
    localparam int COLOR_DEPTH       = 9;
    localparam int SOURCE_SEL_ADDRW  = 3;
endpackage

// File: rtl/draw_source_scheduler_if.sv
// Draw-source bus: scheduler selects a source and flags readiness, the source streams pixels.
// master = scheduler side, slave = draw source side.
interface draw_source_scheduler_if;
    import frame_manager_pkg::*;

    logic [SOURCE_SEL_ADDRW-1:0]  write_source_sel;
    logic                         write_awaited;
    logic                         write_active;
    logic [COLOR_DEPTH-1:0]       write_color_data;
    logic                         write_transparent;
    logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr;
    logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr;

    modport master (
        output write_source_sel, write_awaited,
        input  write_active, write_color_data, write_transparent, write_x_addr, write_y_addr
    );

    modport slave (
        input  write_source_sel, write_awaited,
        output write_active, write_color_data, write_transparent, write_x_addr, write_y_addr
    );
endinterface

// File: rtl/draw_source_scheduler.sv
// Purpose: walks draw sources 0..SOURCE_COUNT-1 once per frame pass, forwarding their pixels to the framebuffer.
// Latency: accepted pixel -> fb_wr_en one cycle later; transparent/off-screen pixels are dropped.
// Backpressure: none; write_awaited gates the source, frame_start while busy is dropped. Optional watchdog: DRAW_SCHED_TIMEOUT_EN.
module draw_source_scheduler
    import frame_manager_pkg::*;
#(
    parameter int SOURCE_COUNT   = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         frame_start,
    draw_source_scheduler_if.master      src,
    output logic                         fb_wr_en,
    output logic [DRAW_WIDTH_ADDRW-1:0]  fb_wr_x,
    output logic [DRAW_HEIGHT_ADDRW-1:0] fb_wr_y,
    output logic [COLOR_DEPTH-1:0]       fb_wr_color,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         frame_overrun,
    output logic                         source_timeout
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_SELECT     = 3'd1;
    localparam logic [2:0] S_WAIT_START = 3'd2;
    localparam logic [2:0] S_DRAWING    = 3'd3;
    localparam logic [2:0] S_NEXT       = 3'd4;
    localparam logic [2:0] S_DONE       = 3'd5;

    localparam logic [SOURCE_SEL_ADDRW-1:0]  LAST_SEL = SOURCE_SEL_ADDRW'(SOURCE_COUNT - 1);
    localparam logic [DRAW_WIDTH_ADDRW:0]    X_LIMIT  = (DRAW_WIDTH_ADDRW + 1)'(DRAW_WIDTH);
    localparam logic [DRAW_HEIGHT_ADDRW:0]   Y_LIMIT  = (DRAW_HEIGHT_ADDRW + 1)'(DRAW_HEIGHT);

    generate
        if (SOURCE_COUNT < 1 || SOURCE_COUNT > (1 << SOURCE_SEL_ADDRW) || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
            $error("draw_source_scheduler: illegal SOURCE_COUNT/TIMEOUT_CYCLES");
        end
    endgenerate

    logic [2:0]                  state;
    logic [2:0]                  state_nxt;
    logic [SOURCE_SEL_ADDRW-1:0] sel;
    logic                        draw_window;
    logic                        pix_accept;
    logic                        pix_visible;
    logic                        wd_expire;

    assign draw_window = (state == S_WAIT_START) || (state == S_DRAWING);
    assign pix_accept  = draw_window && src.write_active;
    assign pix_visible = !src.write_transparent
                      && ({1'b0, src.write_x_addr} < X_LIMIT)
                      && ({1'b0, src.write_y_addr} < Y_LIMIT);

`ifdef DRAW_SCHED_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] wd_cnt;

    assign wd_expire = draw_window && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

    // SELECT always precedes WAIT_START, so clearing there gives a zero count on entry.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wd_cnt         <= '0;
            source_timeout <= 1'b0;
        end else begin
            source_timeout <= wd_expire;
            if (state == S_SELECT)
                wd_cnt <= '0;
            else if (draw_window)
                wd_cnt <= wd_cnt + TW'(1);
        end
    end
`else
    assign wd_expire      = 1'b0;
    assign source_timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       if (frame_start) state_nxt = S_SELECT;
            S_SELECT:     state_nxt = S_WAIT_START;
            S_WAIT_START: if (wd_expire) state_nxt = S_NEXT;
                          else if (src.write_active) state_nxt = S_DRAWING;
            S_DRAWING:    if (wd_expire || !src.write_active) state_nxt = S_NEXT;
            S_NEXT:       state_nxt = (sel == LAST_SEL) ? S_DONE : S_SELECT;
            S_DONE:       state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= S_IDLE;
            sel           <= '0;
            frame_overrun <= 1'b0;
        end else begin
            state         <= state_nxt;
            frame_overrun <= frame_start && (state != S_IDLE);
            if ((state == S_IDLE && frame_start) || state == S_DONE)
                sel <= '0;
            else if (state == S_NEXT && sel != LAST_SEL)
                sel <= sel + SOURCE_SEL_ADDRW'(1);
        end
    end

    // Address/colour only load on a real write so they hold between writes.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fb_wr_en    <= 1'b0;
            fb_wr_x     <= '0;
            fb_wr_y     <= '0;
            fb_wr_color <= '0;
        end else begin
            fb_wr_en <= pix_accept && pix_visible;
            if (pix_accept && pix_visible) begin
                fb_wr_x     <= src.write_x_addr;
                fb_wr_y     <= src.write_y_addr;
                fb_wr_color <= src.write_color_data;
            end
        end
    end

    assign src.write_source_sel = sel;
    assign src.write_awaited    = draw_window;
    assign busy                 = (state != S_IDLE);
    assign frame_done           = (state == S_DONE);

endmodule
